// File: rtl/control_puertas_multi.sv
// control_puertas_multi: Moore door controller for an N-floor elevator car.
// Build option: define PUERTAS_FORZADO_EN for forced close after repeated reopens.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   solicitudes           pending floor requests, one bit per floor
//   piso_actual           floor index the car is at
//   en_movimiento         car is moving
//   boton_abrir/cerrar    cabin open/close buttons (level)
//   sensor                obstruction between the doors
//   fin_apertura/cierre   fully-open / fully-closed limit switches
//   motor_abrir/cerrar    door motor drive (never both high)
//   aviso, atendido       one-hot 1-cycle chime / request-clear pulses
//   trabajando            door busy, car motion must not start
//   falla                 latched fault, cleared only by reset
//   zumbador              forced-close buzzer (optional build only)
//
// The shared timer is loaded with a duration and counts down once per
// cycle; a timed transition fires on the cycle the timer reads zero.
module control_puertas_multi #(
  parameter int NUM_PISOS       = 4,
  parameter int ANCHO_PISO      = 2,
  parameter int TIEMPO_ABIERTA  = 50,
  parameter int TIEMPO_MOTOR    = 20,
  parameter int MAX_REAPERTURAS = 3,
  parameter int ANCHO_CONT      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PISOS-1:0]  solicitudes,
  input  logic [ANCHO_PISO-1:0] piso_actual,
  input  logic                  en_movimiento,
  input  logic                  boton_abrir,
  input  logic                  boton_cerrar,
  input  logic                  sensor,
  input  logic                  fin_apertura,
  input  logic                  fin_cierre,
  output logic                  motor_abrir,
  output logic                  motor_cerrar,
  output logic [NUM_PISOS-1:0]  aviso,
  output logic [NUM_PISOS-1:0]  atendido,
  output logic                  trabajando,
  output logic                  falla,
  output logic                  zumbador
);

  localparam logic [2:0] CERRADA  = 3'd0;
  localparam logic [2:0] ABRIENDO = 3'd1;
  localparam logic [2:0] ABIERTA  = 3'd2;
  localparam logic [2:0] CERRANDO = 3'd3;
  localparam logic [2:0] FALLA    = 3'd4;

  localparam logic [ANCHO_CONT-1:0] T_ABIERTA =
    ANCHO_CONT'(TIEMPO_ABIERTA);
  localparam logic [ANCHO_CONT-1:0] T_MOTOR =
    ANCHO_CONT'(TIEMPO_MOTOR);

  localparam int ANCHO_REAP =
    (MAX_REAPERTURAS < 1) ? 1 : $clog2(MAX_REAPERTURAS + 1);
  localparam logic [ANCHO_REAP-1:0] REAP_MAX =
    ANCHO_REAP'(MAX_REAPERTURAS);

  logic [2:0]            estado;
  logic [2:0]            estado_sig;
  logic [ANCHO_CONT-1:0] cont;
  logic [ANCHO_CONT-1:0] cont_sig;
  logic [NUM_PISOS-1:0]  mask_piso;
  logic [NUM_PISOS-1:0]  aviso_sig;
  logic                  piso_valido;
  logic                  sol_aqui;
  logic                  disparo;
  logic                  reabrir;
  logic                  forzado;
  logic                  forzado_sig;
  logic                  reap_inc;

  // Floor decode; out-of-range indices match no bit and never trigger.
  always_comb begin
    mask_piso = '0;
    for (int i = 0; i < NUM_PISOS; i++) begin
      mask_piso[i] = (piso_actual == ANCHO_PISO'(i));
    end
  end

  assign piso_valido = (int'(piso_actual) < NUM_PISOS);
  assign sol_aqui    = |(solicitudes & mask_piso);
  assign disparo     = !en_movimiento && piso_valido &&
                       (sol_aqui || boton_abrir);

`ifdef PUERTAS_FORZADO_EN
  logic [ANCHO_REAP-1:0] reap;
  logic [ANCHO_REAP-1:0] reap_sig;

  assign forzado = (reap >= REAP_MAX);

  // Saturating reopen count, cleared whenever the door is back closed.
  always_comb begin
    reap_sig = reap;
    if (estado_sig == CERRADA) begin
      reap_sig = '0;
    end else if (reap_inc && (reap < REAP_MAX)) begin
      reap_sig = reap + 1'b1;
    end
  end

  assign forzado_sig = (reap_sig >= REAP_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reap <= '0;
    end else begin
      reap <= reap_sig;
    end
  end
`else
  logic unused_reap;

  assign unused_reap = ^{REAP_MAX, reap_inc};
  assign forzado     = 1'b0;
  assign forzado_sig = 1'b0;
`endif

  // A forced close ignores the obstruction sensor, never the button.
  assign reabrir = boton_abrir || (sensor && !forzado);

  always_comb begin
    estado_sig = estado;
    cont_sig   = cont;
    aviso_sig  = '0;
    reap_inc   = 1'b0;
    if ((estado != CERRADA) && en_movimiento) begin
      estado_sig = FALLA;
    end else if (fin_apertura && fin_cierre) begin
      estado_sig = FALLA;
    end else begin
      unique case (estado)
        CERRADA: begin
          if (disparo) begin
            estado_sig = ABRIENDO;
            cont_sig   = T_MOTOR;
            if (sol_aqui) begin
              aviso_sig = mask_piso;
            end
          end
        end
        ABRIENDO: begin
          if (fin_apertura) begin
            estado_sig = ABIERTA;
            cont_sig   = T_ABIERTA;
          end else if (cont == '0) begin
            estado_sig = FALLA;
          end else begin
            cont_sig = cont - 1'b1;
          end
        end
        ABIERTA: begin
          if (sensor || boton_abrir) begin
            cont_sig = T_ABIERTA;
          end else if (boton_cerrar || (cont == '0)) begin
            estado_sig = CERRANDO;
            cont_sig   = T_MOTOR;
          end else begin
            cont_sig = cont - 1'b1;
          end
        end
        CERRANDO: begin
          if (reabrir) begin
            estado_sig = ABRIENDO;
            cont_sig   = T_MOTOR;
            reap_inc   = 1'b1;
          end else if (fin_cierre) begin
            estado_sig = CERRADA;
          end else if (cont == '0) begin
            estado_sig = FALLA;
          end else begin
            cont_sig = cont - 1'b1;
          end
        end
        FALLA: begin
          estado_sig = FALLA;
        end
        default: begin
          estado_sig = FALLA;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= CERRADA;
      cont   <= '0;
    end else begin
      estado <= estado_sig;
      cont   <= cont_sig;
    end
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      motor_abrir  <= 1'b0;
      motor_cerrar <= 1'b0;
      aviso        <= '0;
      atendido     <= '0;
      trabajando   <= 1'b0;
      falla        <= 1'b0;
      zumbador     <= 1'b0;
    end else begin
      motor_abrir  <= (estado_sig == ABRIENDO);
      motor_cerrar <= (estado_sig == CERRANDO);
      aviso        <= aviso_sig;
      atendido     <= aviso_sig;
      trabajando   <= (estado_sig != CERRADA);
      falla        <= (estado_sig == FALLA);
      zumbador     <= (estado_sig == CERRANDO) && forzado_sig;
    end
  end

endmodule

// File: tb/tb_control_puertas_multi.sv
// tb_control_puertas_multi: scoreboard bench for the door controller.
// Expected output changes are queued with their cycle; a monitor checks them.
module tb_control_puertas_multi;

`ifdef PUERTAS_FORZADO_EN
  localparam bit FORZADO = 1'b1;
`else
  localparam bit FORZADO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] solicitudes = '0;
  logic [2:0] piso_actual = '0;
  logic       en_movimiento = 1'b0;
  logic       boton_abrir = 1'b0;
  logic       boton_cerrar = 1'b0;
  logic       sensor = 1'b0;
  logic       fin_apertura = 1'b0;
  logic       fin_cierre = 1'b0;
  logic       motor_abrir;
  logic       motor_cerrar;
  logic [3:0] aviso;
  logic [3:0] atendido;
  logic       trabajando;
  logic       falla;
  logic       zumbador;

  control_puertas_multi #(
    .NUM_PISOS(4), .ANCHO_PISO(3), .TIEMPO_ABIERTA(50),
    .TIEMPO_MOTOR(20), .MAX_REAPERTURAS(3), .ANCHO_CONT(8)
  ) dut (
    .clk(clk), .reset(reset), .solicitudes(solicitudes),
    .piso_actual(piso_actual), .en_movimiento(en_movimiento),
    .boton_abrir(boton_abrir), .boton_cerrar(boton_cerrar),
    .sensor(sensor), .fin_apertura(fin_apertura),
    .fin_cierre(fin_cierre), .motor_abrir(motor_abrir),
    .motor_cerrar(motor_cerrar), .aviso(aviso),
    .atendido(atendido), .trabajando(trabajando),
    .falla(falla), .zumbador(zumbador)
  );

  always #5 clk = ~clk;

  // {falla, zumbador, trabajando, motor_abrir, motor_cerrar, aviso, atendido}
  logic [12:0] outv;
  assign outv = {falla, zumbador, trabajando, motor_abrir,
                 motor_cerrar, aviso, atendido};

  function automatic logic [12:0] vec(logic fa, logic zu, logic tr,
                                      logic ma, logic mc,
                                      logic [3:0] av, logic [3:0] at);
    return {fa, zu, tr, ma, mc, av, at};
  endfunction

  localparam logic [12:0] V_IDLE    = 13'h0000;
  localparam logic [12:0] V_OPENING = 13'b0011000000000;
  localparam logic [12:0] V_OPEN    = 13'b0010000000000;
  localparam logic [12:0] V_CLOSING = 13'b0010100000000;
  localparam logic [12:0] V_CLOSE_Z = 13'b0110100000000;
  localparam logic [12:0] V_FAULT   = 13'b1010000000000;

  typedef struct {
    logic [12:0] v;
    int          c;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [12:0] prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_out(int dt, logic [12:0] v);
    sb.push_back('{v: v, c: cyc + dt});
  endtask

  task automatic nx(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(string nm, logic [12:0] act, logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs %b, required %b", nm, act, exp);
    end
  endtask

  // Monitor: every change of the output bundle must match the next entry.
  always @(negedge clk) begin
    exp_t e;
    if (outv !== prev) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: outputs %b at cycle %0d, required %b",
                 outv, cyc, prev);
      end else begin
        e = sb.pop_front();
        if (outv !== e.v || cyc != e.c) begin
          n_fail++;
          $display("FAIL change: outputs %b at cycle %0d, required %b at cycle %0d",
                   outv, cyc, e.v, e.c);
        end
      end
    end
    prev = outv;
  end

  task automatic do_reset(bit busy);
    #2;
    reset = 1'b1;
    solicitudes = '0;
    piso_actual = '0;
    en_movimiento = 1'b0;
    boton_abrir = 1'b0;
    boton_cerrar = 1'b0;
    sensor = 1'b0;
    fin_apertura = 1'b0;
    fin_cierre = 1'b0;
    if (busy) expect_out(1, V_IDLE);
    #1;
    chk("async_reset", outv, V_IDLE);
    nx();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    nx(2);
    reset = 1'b0;
    chk("reset_state", outv, V_IDLE);

    // Service with chime at floor 2, auto-close after the dwell
    piso_actual = 3'd2;
    solicitudes = 4'b0100;
    expect_out(1, vec(0, 0, 1, 1, 0, 4'b0100, 4'b0100));
    expect_out(2, V_OPENING);
    nx();
    solicitudes = '0;
    nx(3);
    fin_apertura = 1'b1;
    expect_out(1, V_OPEN);
    nx();
    fin_apertura = 1'b0;
    expect_out(51, V_CLOSING);
    nx(51);
    fin_cierre = 1'b1;
    expect_out(1, V_IDLE);
    nx();
    fin_cierre = 1'b0;

    // Button-only open, no chime; sensor pulses hold the door open
    piso_actual = 3'd1;
    boton_abrir = 1'b1;
    expect_out(1, V_OPENING);
    nx();
    boton_abrir = 1'b0;
    fin_apertura = 1'b1;
    expect_out(1, V_OPEN);
    nx();
    fin_apertura = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nx(29);
      sensor = 1'b1;
      nx();
      sensor = 1'b0;
    end
    expect_out(51, V_CLOSING);
    nx(51);

    // Obstruction while closing reopens; then motor timeout
    sensor = 1'b1;
    expect_out(1, V_OPENING);
    nx();
    sensor = 1'b0;
    expect_out(21, V_FAULT);
    nx(23);
    do_reset(1'b1);

    // Chime at floor 0; open beats close; close button
    piso_actual = 3'd0;
    solicitudes = 4'b0001;
    boton_abrir = 1'b1;
    expect_out(1, vec(0, 0, 1, 1, 0, 4'b0001, 4'b0001));
    nx();
    solicitudes = '0;
    boton_abrir = 1'b0;
    fin_apertura = 1'b1;
    expect_out(1, V_OPEN);
    nx();
    fin_apertura = 1'b0;
    boton_abrir = 1'b1;
    boton_cerrar = 1'b1;
    nx(3);
    boton_abrir = 1'b0;
    expect_out(1, V_CLOSING);
    nx();
    boton_cerrar = 1'b0;
    fin_cierre = 1'b1;
    expect_out(1, V_IDLE);
    nx();
    fin_cierre = 1'b0;

    // Car motion while open is a fault
    boton_abrir = 1'b1;
    expect_out(1, V_OPENING);
    nx();
    boton_abrir = 1'b0;
    fin_apertura = 1'b1;
    expect_out(1, V_OPEN);
    nx();
    fin_apertura = 1'b0;
    nx(4);
    en_movimiento = 1'b1;
    expect_out(1, V_FAULT);
    nx();
    do_reset(1'b1);

    // Out-of-range floor and moving car never trigger service
    piso_actual = 3'd5;
    solicitudes = 4'b1111;
    boton_abrir = 1'b1;
    nx(4);
    piso_actual = 3'd1;
    en_movimiento = 1'b1;
    nx(4);
    en_movimiento = 1'b0;
    boton_abrir = 1'b0;
    solicitudes = '0;
    piso_actual = '0;
    nx();
    chk("no_service", outv, V_IDLE);

    // Both limit switches at once
    fin_apertura = 1'b1;
    fin_cierre = 1'b1;
    expect_out(1, V_FAULT);
    nx();
    do_reset(1'b1);

    // Repeated sensor reopens at floor 3
    piso_actual = 3'd3;
    solicitudes = 4'b1000;
    expect_out(1, vec(0, 0, 1, 1, 0, 4'b1000, 4'b1000));
    expect_out(2, V_OPENING);
    nx();
    solicitudes = '0;
    nx();
    fin_apertura = 1'b1;
    expect_out(1, V_OPEN);
    nx();
    fin_apertura = 1'b0;
    boton_cerrar = 1'b1;
    expect_out(1, V_CLOSING);
    nx();
    boton_cerrar = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sensor = 1'b1;
      if (FORZADO && k == 4) begin
        nx(3);
        fin_cierre = 1'b1;
        expect_out(1, V_IDLE);
        nx();
        fin_cierre = 1'b0;
        sensor = 1'b0;
      end else begin
        expect_out(1, V_OPENING);
        nx();
        sensor = 1'b0;
        fin_apertura = 1'b1;
        expect_out(1, V_OPEN);
        nx();
        fin_apertura = 1'b0;
        boton_cerrar = 1'b1;
        expect_out(1, (FORZADO && k == 3) ? V_CLOSE_Z : V_CLOSING);
        nx();
        boton_cerrar = 1'b0;
      end
    end
    if (!FORZADO) begin
      fin_cierre = 1'b1;
      expect_out(1, V_IDLE);
      nx();
      fin_cierre = 1'b0;
    end

    nx(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations: %0d left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
